// File: rtl/hft_order_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hft_order_pkg
// Description : Shared types and constants for the outbound quote order path.
//               quote_t holds stock id / prices at their maximum on-wire
//               widths (8-bit id, 32-bit prices) so narrower configurations
//               simply zero-extend into it.
// Revision    : 1.0 - initial release
// ============================================================================
package hft_order_pkg;

    localparam logic [3:0] MSG_QUOTE = 4'hA;
    localparam logic [3:0] SIDE_BUY  = 4'h1;
    localparam logic [3:0] SIDE_SELL = 4'h2;

    localparam int QUOTE_ID_W = 8;
    localparam int QUOTE_PX_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_BID_HDR = 3'd1,
        ST_BID_PX  = 3'd2,
        ST_ASK_HDR = 3'd3,
        ST_ASK_PX  = 3'd4
    } tx_state_t;

    typedef struct packed {
        logic [QUOTE_ID_W-1:0] stock_id;
        logic [QUOTE_PX_W-1:0] buy;
        logic [QUOTE_PX_W-1:0] sell;
    } quote_t;

    // Header word: {type, side, stock id, sequence number}
    function automatic logic [31:0] make_header(input logic [3:0]  side,
                                                input logic [7:0]  stock_id,
                                                input logic [15:0] seq);
        return {MSG_QUOTE, side, stock_id, seq};
    endfunction

endpackage
`default_nettype wire

// File: rtl/quote_dedup_table.sv
`default_nettype none
// ============================================================================
// Module      : quote_dedup_table
// Description : Per-stock record of the last {bid, ask} sent, with a valid
//               bit per entry. o_hit flags a lookup quote identical to a
//               valid stored entry for the same stock.
// Ports       : i_clk, i_reset_n (sync, active-low, clears valid bits only)
//               i_lkp_id/buy/sell -> o_hit     combinational lookup
//               i_wr_en, i_wr_id/buy/sell      entry write
// Revision    : 1.0 - initial release
// ============================================================================
module quote_dedup_table #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_STOCKS = 4
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    input  logic [$clog2(NUM_STOCKS)-1:0] i_lkp_id,
    input  logic [DATA_WIDTH-1:0]         i_lkp_buy,
    input  logic [DATA_WIDTH-1:0]         i_lkp_sell,
    output logic                          o_hit,
    input  logic                          i_wr_en,
    input  logic [$clog2(NUM_STOCKS)-1:0] i_wr_id,
    input  logic [DATA_WIDTH-1:0]         i_wr_buy,
    input  logic [DATA_WIDTH-1:0]         i_wr_sell
);

    logic [DATA_WIDTH-1:0] buy_q  [NUM_STOCKS];
    logic [DATA_WIDTH-1:0] buy_d  [NUM_STOCKS];
    logic [DATA_WIDTH-1:0] sell_q [NUM_STOCKS];
    logic [DATA_WIDTH-1:0] sell_d [NUM_STOCKS];
    logic [NUM_STOCKS-1:0] vld_q;
    logic [NUM_STOCKS-1:0] vld_d;

    always_comb begin
        buy_d  = buy_q;
        sell_d = sell_q;
        vld_d  = vld_q;
        if (i_wr_en) begin
            buy_d[i_wr_id]  = i_wr_buy;
            sell_d[i_wr_id] = i_wr_sell;
            vld_d[i_wr_id]  = 1'b1;
        end
    end

    // Price storage needs no reset: entries are ignored until their valid bit is set.
    always_ff @(posedge i_clk) begin
        buy_q  <= buy_d;
        sell_q <= sell_d;
        if (!i_reset_n) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    assign o_hit = vld_q[i_lkp_id]
                 && (buy_q[i_lkp_id]  == i_lkp_buy)
                 && (sell_q[i_lkp_id] == i_lkp_sell);

endmodule
`default_nettype wire

// File: rtl/quote_order_tx.sv
`default_nettype none
// ============================================================================
// Module      : quote_order_tx
// Description : Serialises accepted quotes into 4-word order messages
//               (bid header, bid price, ask header, ask price) on a 32-bit
//               valid/ready stream. A one-entry newest-wins pending register
//               absorbs back-pressure; overwritten quotes are counted.
//               Optional macro QUOTE_TX_DEDUP_EN discards quotes identical
//               to the last message sent for the same stock.
// Ports       : i_clk, i_reset_n (sync, active-low)
//               i_buy_price, i_sell_price, i_stock_id, i_data_valid  quote in
//               o_tx_data, o_tx_valid, i_tx_ready                    stream out
//               o_busy, o_seq_num, o_drop_count                      status
// Revision    : 1.0 - initial release
// ============================================================================
module quote_order_tx
    import hft_order_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_STOCKS     = 4,
    parameter int SEQ_WIDTH      = 16,
    parameter int DROP_CNT_WIDTH = 16
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    input  logic [DATA_WIDTH-1:0]         i_buy_price,
    input  logic [DATA_WIDTH-1:0]         i_sell_price,
    input  logic [$clog2(NUM_STOCKS)-1:0] i_stock_id,
    input  logic                          i_data_valid,
    output logic [31:0]                   o_tx_data,
    output logic                          o_tx_valid,
    input  logic                          i_tx_ready,
    output logic                          o_busy,
    output logic [SEQ_WIDTH-1:0]          o_seq_num,
    output logic [DROP_CNT_WIDTH-1:0]     o_drop_count
);

    localparam int ID_W = $clog2(NUM_STOCKS);

    tx_state_t                 state_q, state_d;
    quote_t                    active_q, active_d;
    quote_t                    pend_q, pend_d;
    logic                      pend_vld_q, pend_vld_d;
    logic [SEQ_WIDTH-1:0]      seq_q, seq_d;
    logic [DROP_CNT_WIDTH-1:0] drop_q, drop_d;

    quote_t      w_in_quote;
    logic        w_dup;
    logic        w_accept;
    logic        w_fire;
    logic        w_last_fire;
    logic [15:0] w_seq16;

    always_comb begin
        w_in_quote          = '0;
        w_in_quote.stock_id = QUOTE_ID_W'(i_stock_id);
        w_in_quote.buy      = QUOTE_PX_W'(i_buy_price);
        w_in_quote.sell     = QUOTE_PX_W'(i_sell_price);
    end

    assign w_fire      = o_tx_valid & i_tx_ready;
    assign w_last_fire = (state_q == ST_ASK_PX) & w_fire;
    assign w_seq16     = 16'(seq_q);

`ifdef QUOTE_TX_DEDUP_EN
    // Table is updated with the message just completed on its final handshake.
    quote_dedup_table #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_STOCKS (NUM_STOCKS)
    ) u_dedup (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_lkp_id   (i_stock_id),
        .i_lkp_buy  (i_buy_price),
        .i_lkp_sell (i_sell_price),
        .o_hit      (w_dup),
        .i_wr_en    (w_last_fire),
        .i_wr_id    (active_q.stock_id[ID_W-1:0]),
        .i_wr_buy   (active_q.buy[DATA_WIDTH-1:0]),
        .i_wr_sell  (active_q.sell[DATA_WIDTH-1:0])
    );
`else
    assign w_dup = 1'b0;
`endif

    assign w_accept = i_data_valid & ~w_dup;

    always_comb begin
        state_d    = state_q;
        active_d   = active_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        seq_d      = seq_q;
        drop_d     = drop_q;

        case (state_q)
            ST_BID_HDR: if (w_fire) state_d = ST_BID_PX;
            ST_BID_PX:  if (w_fire) state_d = ST_ASK_HDR;
            ST_ASK_HDR: if (w_fire) state_d = ST_ASK_PX;
            default:    state_d = state_q;
        endcase

        if (w_last_fire) begin
            seq_d = seq_q + SEQ_WIDTH'(1);
            if (pend_vld_q) begin
                // Held quote goes out next; a same-cycle arrival takes its
                // slot without counting as a drop.
                active_d   = pend_q;
                state_d    = ST_BID_HDR;
                pend_vld_d = w_accept;
                if (w_accept) pend_d = w_in_quote;
            end else if (w_accept) begin
                active_d = w_in_quote;
                state_d  = ST_BID_HDR;
            end else begin
                state_d = ST_IDLE;
            end
        end else if ((state_q == ST_IDLE) && !pend_vld_q && w_accept) begin
            active_d = w_in_quote;
            state_d  = ST_BID_HDR;
        end else if (w_accept) begin
            pend_d     = w_in_quote;
            pend_vld_d = 1'b1;
            if (pend_vld_q && (drop_q != {DROP_CNT_WIDTH{1'b1}})) begin
                drop_d = drop_q + DROP_CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q    <= ST_IDLE;
            active_q   <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            seq_q      <= '0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            active_q   <= active_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            seq_q      <= seq_d;
            drop_q     <= drop_d;
        end
    end

    // Output word depends only on registered state, so it is stable while stalled.
    always_comb begin
        o_tx_data = 32'h0;
        case (state_q)
            ST_BID_HDR: o_tx_data = make_header(SIDE_BUY,  active_q.stock_id, w_seq16);
            ST_BID_PX:  o_tx_data = active_q.buy;
            ST_ASK_HDR: o_tx_data = make_header(SIDE_SELL, active_q.stock_id, w_seq16);
            ST_ASK_PX:  o_tx_data = active_q.sell;
            default:    o_tx_data = 32'h0;
        endcase
    end

    assign o_tx_valid   = (state_q != ST_IDLE);
    assign o_busy       = o_tx_valid | pend_vld_q;
    assign o_seq_num    = seq_q;
    assign o_drop_count = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_quote_order_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_quote_order_tx
// Description : Directed self-checking bench for quote_order_tx. The DUT is
//               built with a 4-bit sequence number so the all-ones -> 0 wrap
//               is reached in a few dozen messages.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_quote_order_tx;

    localparam int DW  = 32;
    localparam int NS  = 4;
    localparam int SW  = 4;
    localparam int DCW = 16;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [DW-1:0]  buy_price;
    logic [DW-1:0]  sell_price;
    logic [1:0]     stock_id;
    logic           data_valid;
    logic [31:0]    tx_data;
    logic           tx_valid;
    logic           tx_ready;
    logic           busy;
    logic [SW-1:0]  seq_num;
    logic [DCW-1:0] drop_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    quote_order_tx #(
        .DATA_WIDTH     (DW),
        .NUM_STOCKS     (NS),
        .SEQ_WIDTH      (SW),
        .DROP_CNT_WIDTH (DCW)
    ) dut (
        .i_clk        (clk),
        .i_reset_n    (reset_n),
        .i_buy_price  (buy_price),
        .i_sell_price (sell_price),
        .i_stock_id   (stock_id),
        .i_data_valid (data_valid),
        .o_tx_data    (tx_data),
        .o_tx_valid   (tx_valid),
        .i_tx_ready   (tx_ready),
        .o_busy       (busy),
        .o_seq_num    (seq_num),
        .o_drop_count (drop_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] hdr(input logic [3:0] side, input int id, input int seq);
        logic [7:0]  id8;
        logic [15:0] s16;
        id8 = 8'(id);
        s16 = 16'(seq);
        return {4'hA, side, id8, s16};
    endfunction

    task automatic set_quote(input int id, input logic [31:0] b, input logic [31:0] a);
        stock_id   = 2'(id);
        buy_price  = b;
        sell_price = a;
    endtask

    task automatic pulse(input int id, input logic [31:0] b, input logic [31:0] a);
        set_quote(id, b, a);
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
    endtask

    // Entered in BID_HDR with ready high; returns while ASK_PX is presented.
    task automatic expect_msg(input int id, input logic [31:0] b, input logic [31:0] a, input int seq);
        check("msg_valid", 32'(tx_valid), 32'd1);
        check("bid_hdr", tx_data, hdr(4'h1, id, seq));
        tick();
        check("bid_px", tx_data, b);
        tick();
        check("ask_hdr", tx_data, hdr(4'h2, id, seq));
        tick();
        check("ask_px", tx_data, a);
        check("ask_valid", 32'(tx_valid), 32'd1);
    endtask

    initial begin
        reset_n    = 1'b0;
        data_valid = 1'b0;
        tx_ready   = 1'b1;
        set_quote(0, 32'h0, 32'h0);
        tick();
        tick();
        check("rst_valid", 32'(tx_valid), 32'd0);
        check("rst_data", tx_data, 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_seq", 32'(seq_num), 32'd0);
        check("rst_drop", 32'(drop_count), 32'd0);

        // Single quote, ready held high, first word one cycle after input
        reset_n = 1'b1;
        pulse(2, 32'h0000_1F40, 32'h0000_1F54);
        check("t1_w0", tx_data, 32'hA102_0000);
        check("t1_v0", 32'(tx_valid), 32'd1);
        tick();
        check("t1_w1", tx_data, 32'h0000_1F40);
        tick();
        check("t1_w2", tx_data, 32'hA202_0000);
        tick();
        check("t1_w3", tx_data, 32'h0000_1F54);
        tick();
        check("t1_idle_valid", 32'(tx_valid), 32'd0);
        check("t1_seq", 32'(seq_num), 32'd1);
        check("t1_busy", 32'(busy), 32'd0);

        // Back-pressure for 3 cycles in BID_PX
        pulse(2, 32'h0000_1F40, 32'h0000_1F54);
        check("t2_hdr", tx_data, 32'hA102_0001);
        tick();
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_hold_data", tx_data, 32'h0000_1F40);
            check("t2_hold_valid", 32'(tx_valid), 32'd1);
        end
        tx_ready = 1'b1;
        tick();
        check("t2_ask_hdr", tx_data, 32'hA202_0001);
        tick();
        check("t2_ask_px", tx_data, 32'h0000_1F54);
        tick();
        check("t2_seq", 32'(seq_num), 32'd2);

        // Overflow: A active, B overwritten by C in pending
        pulse(0, 32'h10, 32'h11);
        tx_ready = 1'b0;
        pulse(1, 32'h20, 32'h21);
        pulse(3, 32'h30, 32'h31);
        check("t3_drop", 32'(drop_count), 32'd1);
        check("t3_busy", 32'(busy), 32'd1);
        check("t3_stall_hdr", tx_data, 32'hA100_0002);
        tx_ready = 1'b1;
        expect_msg(0, 32'h10, 32'h11, 2);
        tick();
        expect_msg(3, 32'h30, 32'h31, 3);
        tick();
        check("t3_idle", 32'(tx_valid), 32'd0);
        check("t3_seq", 32'(seq_num), 32'd4);
        check("t3_drop_end", 32'(drop_count), 32'd1);

        // Quote arriving on the ASK_PX handshake: back-to-back messages
        pulse(1, 32'h40, 32'h41);
        expect_msg(1, 32'h40, 32'h41, 4);
        set_quote(2, 32'h50, 32'h51);
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        expect_msg(2, 32'h50, 32'h51, 5);
        tick();
        check("t4_drop", 32'(drop_count), 32'd1);

        // Sequence wrap: advance to all-ones, then expect 0
        for (int s = 6; s < 15; s++) begin
            pulse(3, 32'(s), 32'(s + 100));
            expect_msg(3, 32'(s), 32'(s + 100), s);
            tick();
        end
        check("t5_seq_max", 32'(seq_num), 32'd15);
        pulse(2, 32'hDEAD_BEEF, 32'h0123_4567);
        expect_msg(2, 32'hDEAD_BEEF, 32'h0123_4567, 15);
        tick();
        check("t5_seq_wrap", 32'(seq_num), 32'd0);
        pulse(1, 32'h77, 32'h78);
        expect_msg(1, 32'h77, 32'h78, 0);
        tick();

        // Reset during ASK_HDR with a pending quote held
        pulse(0, 32'h60, 32'h61);
        tick();
        set_quote(1, 32'h70, 32'h71);
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        check("t6_ask_hdr", tx_data, 32'hA200_0001);
        check("t6_busy_pre", 32'(busy), 32'd1);
        reset_n = 1'b0;
        tick();
        check("t6_valid", 32'(tx_valid), 32'd0);
        check("t6_seq", 32'(seq_num), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_drop", 32'(drop_count), 32'd0);
        reset_n = 1'b1;
        tick();
        tick();
        check("t6_no_resume", 32'(tx_valid), 32'd0);
        check("t6_pend_gone", 32'(busy), 32'd0);

        // Repeated identical quote for stock 1, then ask changed by one
        pulse(1, 32'h100, 32'h200);
        expect_msg(1, 32'h100, 32'h200, 0);
        tick();
        pulse(1, 32'h100, 32'h200);
`ifdef QUOTE_TX_DEDUP_EN
        check("t7_dup_valid", 32'(tx_valid), 32'd0);
        check("t7_dup_busy", 32'(busy), 32'd0);
        check("t7_dup_seq", 32'(seq_num), 32'd1);
        pulse(1, 32'h100, 32'h201);
        expect_msg(1, 32'h100, 32'h201, 1);
        tick();
        check("t7_seq_end", 32'(seq_num), 32'd2);
`else
        expect_msg(1, 32'h100, 32'h200, 1);
        tick();
        pulse(1, 32'h100, 32'h201);
        expect_msg(1, 32'h100, 32'h201, 2);
        tick();
        check("t7_seq_end", 32'(seq_num), 32'd3);
`endif
        check("t7_drop_end", 32'(drop_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
